// File: rtl/riscv_inst_fetch_if.sv
// rtl/riscv_inst_fetch_if.sv - instruction-memory read port between fetch unit and memory
interface riscv_inst_fetch_if;
  logic        o_MemReq;
  logic [31:0] o_MemAddr;
  logic        i_MemAck;
  logic [31:0] i_MemData;

  modport master (output o_MemReq, output o_MemAddr, input i_MemAck, input i_MemData);
  modport slave  (input o_MemReq, input o_MemAddr, output i_MemAck, output i_MemData);
endinterface

// File: rtl/riscv_inst_fetch.sv
// rtl/riscv_inst_fetch.sv - multi-cycle RISC-V instruction fetch unit with IR and misalign trap
module riscv_inst_fetch #(
  parameter logic [31:0] P_RESET_PC = 32'h0000_0000,
  parameter logic [31:0] P_NOP      = 32'h0000_0013
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  riscv_inst_fetch_if.master        mem,
  input  logic                      i_Advance,
  input  logic                      i_PcLoad,
  input  logic [31:0]               i_PcTarget,
  output logic [31:0]               o_Inst,
  output logic [6:0]                o_OpCode,
  output logic [31:0]               o_Pc,
  output logic                      o_InstValid,
  output logic                      o_Busy,
  output logic                      o_MisalignErr
);

  typedef enum logic [1:0] {S_FETCH, S_VALID, S_ERR} state_t;

  state_t      state, state_d;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        misaligned;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= S_FETCH;
    else       state <= state_d;
  end

  always_comb begin
    state_d    = state;
    next_pc    = i_PcLoad ? i_PcTarget : pc + 32'd4;
    misaligned = (next_pc[1:0] != 2'b00);
    case (state)
      S_FETCH: if (mem.i_MemAck) state_d = S_VALID;
      S_VALID: if (i_Advance)    state_d = misaligned ? S_ERR : S_FETCH;
      default: state_d = state;
    endcase
  end

  // PC only moves on a clean advance, so a trap leaves the faulting PC visible
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      pc            <= P_RESET_PC;
      o_Inst        <= P_NOP;
      o_Pc          <= P_RESET_PC;
      o_InstValid   <= 1'b0;
      o_MisalignErr <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem.i_MemAck) begin
            o_Inst      <= mem.i_MemData;
            o_Pc        <= pc;
            o_InstValid <= 1'b1;
          end
        end
        S_VALID: begin
          if (i_Advance) begin
            o_InstValid <= 1'b0;
            if (misaligned) o_MisalignErr <= 1'b1;
            else            pc <= next_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.o_MemReq  = (state == S_FETCH);
  assign mem.o_MemAddr = pc;
  assign o_Busy        = (state == S_FETCH);
  assign o_OpCode      = o_Inst[6:0];

endmodule

// File: tb/tb_riscv_inst_fetch.sv
// tb/tb_riscv_inst_fetch.sv - directed scoreboard bench for riscv_inst_fetch
module tb_riscv_inst_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_t;

  logic        clk = 1'b0;
  logic        rst_a, adv_a, load_a;
  logic [31:0] tgt_a;
  logic [31:0] inst_a, pc_a;
  logic [6:0]  op_a;
  logic        valid_a, busy_a, err_a;

  logic        rst_b, adv_b, load_b;
  logic [31:0] tgt_b;
  logic [31:0] inst_b, pc_b;
  logic [6:0]  op_b;
  logic        valid_b, busy_b, err_b;

  int tests = 0;
  int fails = 0;
  fetch_t sb[$];
  logic [31:0] model_pc;

  riscv_inst_fetch_if bus_a ();
  riscv_inst_fetch_if bus_b ();

  riscv_inst_fetch dut_a (
    .i_Clk(clk), .i_Rst(rst_a), .mem(bus_a.master),
    .i_Advance(adv_a), .i_PcLoad(load_a), .i_PcTarget(tgt_a),
    .o_Inst(inst_a), .o_OpCode(op_a), .o_Pc(pc_a),
    .o_InstValid(valid_a), .o_Busy(busy_a), .o_MisalignErr(err_a)
  );

  riscv_inst_fetch #(.P_RESET_PC(32'hFFFF_FFFC)) dut_b (
    .i_Clk(clk), .i_Rst(rst_b), .mem(bus_b.master),
    .i_Advance(adv_b), .i_PcLoad(load_b), .i_PcTarget(tgt_b),
    .o_Inst(inst_b), .o_OpCode(op_b), .o_Pc(pc_b),
    .o_InstValid(valid_b), .o_Busy(busy_b), .o_MisalignErr(err_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle ack on dut_a and score the captured instruction
  task automatic ack_a(input logic [31:0] data);
    fetch_t e;
    bus_a.i_MemAck  = 1'b1;
    bus_a.i_MemData = data;
    sb.push_back('{inst: data, pc: model_pc});
    tick();
    bus_a.i_MemAck  = 1'b0;
    bus_a.i_MemData = 32'h0;
    check("valid_after_ack", {31'b0, valid_a}, 32'd1);
    if (sb.size() == 0) begin
      tests++; fails++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check("ir_capture", inst_a, e.inst);
      check("pc_capture", pc_a, e.pc);
      check("opcode_capture", {25'b0, op_a}, {25'b0, e.inst[6:0]});
    end
  endtask

  task automatic advance_a(input logic load, input logic [31:0] tgt);
    adv_a = 1'b1; load_a = load; tgt_a = tgt;
    tick();
    adv_a = 1'b0; load_a = 1'b0; tgt_a = 32'h0;
  endtask

  initial begin
    rst_a = 1'b1; adv_a = 1'b0; load_a = 1'b0; tgt_a = 32'h0;
    bus_a.i_MemAck = 1'b0; bus_a.i_MemData = 32'h0;
    rst_b = 1'b1; adv_b = 1'b0; load_b = 1'b0; tgt_b = 32'h0;
    bus_b.i_MemAck = 1'b0; bus_b.i_MemData = 32'h0;
    tick();
    rst_a = 1'b0; rst_b = 1'b0;
    model_pc = 32'h0;

    check("rst_memreq", {31'b0, bus_a.o_MemReq}, 32'd1);
    check("rst_memaddr", bus_a.o_MemAddr, 32'h0);
    check("rst_busy", {31'b0, busy_a}, 32'd1);
    check("rst_opcode", {25'b0, op_a}, 32'h13);
    check("rst_ir", inst_a, NOP);
    check("rst_pc", pc_a, 32'h0);
    check("rst_valid", {31'b0, valid_a}, 32'd0);
    check("rst_err", {31'b0, err_a}, 32'd0);

    // two wait cycles with a spurious advance/branch request that must be ignored
    adv_a = 1'b1; load_a = 1'b1; tgt_a = 32'h0000_0200;
    tick();
    adv_a = 1'b0; load_a = 1'b0; tgt_a = 32'h0;
    tick();
    check("wait_memaddr", bus_a.o_MemAddr, 32'h0);
    check("wait_ir", inst_a, NOP);
    check("wait_memreq", {31'b0, bus_a.o_MemReq}, 32'd1);

    ack_a(32'h0050_0093);
    check("valid_memreq", {31'b0, bus_a.o_MemReq}, 32'd0);
    check("valid_busy", {31'b0, busy_a}, 32'd0);

    // spurious ack and PcLoad without advance while valid
    bus_a.i_MemAck = 1'b1; bus_a.i_MemData = 32'hDEAD_BEEF;
    load_a = 1'b1; tgt_a = 32'h0000_0300;
    tick();
    tick();
    bus_a.i_MemAck = 1'b0; bus_a.i_MemData = 32'h0;
    load_a = 1'b0; tgt_a = 32'h0;
    check("spur_ir", inst_a, 32'h0050_0093);
    check("spur_pc", pc_a, 32'h0);
    check("spur_memaddr", bus_a.o_MemAddr, 32'h0);
    check("spur_valid", {31'b0, valid_a}, 32'd1);

    advance_a(1'b0, 32'h0);
    model_pc = model_pc + 32'd4;
    check("seq_memaddr", bus_a.o_MemAddr, 32'h4);
    check("seq_memreq", {31'b0, bus_a.o_MemReq}, 32'd1);
    check("seq_valid", {31'b0, valid_a}, 32'd0);
    check("seq_ir_hold", inst_a, 32'h0050_0093);

    ack_a(32'h00A0_0113);

    advance_a(1'b1, 32'h0000_0100);
    model_pc = 32'h0000_0100;
    check("br_memaddr", bus_a.o_MemAddr, 32'h100);
    check("br_valid", {31'b0, valid_a}, 32'd0);

    ack_a(32'h0000_006F);

    advance_a(1'b1, 32'h0000_0102);
    check("mis_err", {31'b0, err_a}, 32'd1);
    check("mis_memreq", {31'b0, bus_a.o_MemReq}, 32'd0);
    check("mis_valid", {31'b0, valid_a}, 32'd0);
    check("mis_memaddr", bus_a.o_MemAddr, 32'h100);

    for (int i = 0; i < 3; i++) begin
      bus_a.i_MemAck = 1'b1; bus_a.i_MemData = 32'h1234_5678;
      adv_a = 1'b1; load_a = 1'b1; tgt_a = 32'h0000_0040;
      tick();
    end
    bus_a.i_MemAck = 1'b0; adv_a = 1'b0; load_a = 1'b0; tgt_a = 32'h0;
    check("err_sticky", {31'b0, err_a}, 32'd1);
    check("err_memreq", {31'b0, bus_a.o_MemReq}, 32'd0);
    check("err_busy", {31'b0, busy_a}, 32'd0);
    check("err_memaddr", bus_a.o_MemAddr, 32'h100);
    check("err_ir", inst_a, 32'h0000_006F);

    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    model_pc = 32'h0;
    check("clr_err", {31'b0, err_a}, 32'd0);
    check("clr_memreq", {31'b0, bus_a.o_MemReq}, 32'd1);
    check("clr_memaddr", bus_a.o_MemAddr, 32'h0);

    // move to a non-reset PC, then reset and ack on the same edge
    ack_a(32'h0000_0013);
    advance_a(1'b1, 32'h0000_0008);
    check("pre_rst_memaddr", bus_a.o_MemAddr, 32'h8);
    rst_a = 1'b1; bus_a.i_MemAck = 1'b1; bus_a.i_MemData = 32'hCAFE_F00D;
    tick();
    rst_a = 1'b0; bus_a.i_MemAck = 1'b0; bus_a.i_MemData = 32'h0;
    check("rstack_ir", inst_a, NOP);
    check("rstack_valid", {31'b0, valid_a}, 32'd0);
    check("rstack_memaddr", bus_a.o_MemAddr, 32'h0);
    check("rstack_pc", pc_a, 32'h0);

    // wrap-around on the high reset-PC instance
    check("wrap_rst_memaddr", bus_b.o_MemAddr, 32'hFFFF_FFFC);
    bus_b.i_MemAck = 1'b1; bus_b.i_MemData = 32'h0010_0093;
    tick();
    bus_b.i_MemAck = 1'b0;
    check("wrap_valid", {31'b0, valid_b}, 32'd1);
    check("wrap_pc", pc_b, 32'hFFFF_FFFC);
    adv_b = 1'b1;
    tick();
    adv_b = 1'b0;
    check("wrap_memaddr", bus_b.o_MemAddr, 32'h0);
    check("wrap_memreq", {31'b0, bus_b.o_MemReq}, 32'd1);
    check("wrap_err", {31'b0, err_b}, 32'd0);

    if (sb.size() != 0) begin
      tests++; fails++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/riscv_inst_fetch.md
RISCV_INST_FETCH -- requirements
Module: riscv_inst_fetch

Interface
REQ-001 The block SHALL have parameter P_RESET_PC, default 32'h0000_0000, which is the PC loaded on reset.
REQ-002 The block SHALL have parameter P_NOP, default 32'h0000_0013 (ADDI x0,x0,0), which is the IR value after reset.
REQ-003 The block SHALL have port i_Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_Rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port i_Advance  input  1  control FSM request to retire the current instruction and fetch the next one.
REQ-006 The block SHALL have port i_PcLoad  input  1  qualifies i_Advance: take i_PcTarget instead of PC+4.
REQ-007 The block SHALL have port i_PcTarget  input  32  branch/jump target.
REQ-008 The block SHALL have port o_MemReq  output  1  instruction-memory read request.
REQ-009 The block SHALL have port o_MemAddr  output  32  instruction-memory byte address.
REQ-010 The block SHALL have port i_MemAck  input  1  memory returns valid data this cycle.
REQ-011 The block SHALL have port i_MemData  input  32  instruction word from memory.
REQ-012 The block SHALL have port o_Inst  output  32  instruction register (IR), which feeds the immediate generator and the decoder.
REQ-013 The block SHALL have port o_OpCode  output  7  equal to o_Inst[6:0] at all times.
REQ-014 The block SHALL have port o_Pc  output  32  address of the instruction held in IR.
REQ-015 The block SHALL have port o_InstValid  output  1  IR holds a fetched, unretired instruction.
REQ-016 The block SHALL have port o_Busy  output  1  fetch in progress.
REQ-017 The block SHALL have port o_MisalignErr  output  1  sticky misaligned-target error.

Function
REQ-018 The FSM SHALL have three states: S_FETCH, S_VALID and S_ERR.
REQ-019 In S_FETCH the block SHALL drive o_MemReq=1, o_Busy=1 and o_MemAddr=PC.
REQ-020 In S_FETCH with i_MemAck=1, on the same edge: IR<=i_MemData; o_Pc<=PC; o_InstValid<=1; state<=S_VALID.
REQ-021 Data acceptance SHALL have zero-wait latency: an ack in the first request cycle makes IR valid on the next cycle.
REQ-022 In S_FETCH, i_Advance and i_PcLoad SHALL be ignored, and PC, IR and o_Pc SHALL hold.
REQ-023 In S_VALID the block SHALL drive o_MemReq=0 and o_Busy=0, and IR and o_Pc SHALL hold until i_Advance=1.
REQ-024 In S_VALID with i_Advance=1, the block SHALL compute next = i_PcLoad ? i_PcTarget : PC+4, where PC+4 is 32-bit modulo (32'hFFFF_FFFC wraps to 0).
REQ-025 If next[1:0]==2'b00, the block SHALL set PC<=next, o_InstValid<=0 and state<=S_FETCH, and o_MemReq SHALL assert on the following cycle.
REQ-026 If next[1:0]!=2'b00, the block SHALL set o_MisalignErr<=1, o_InstValid<=0 and state<=S_ERR; PC SHALL NOT be updated, so o_MemAddr keeps showing the faulting instruction's PC.
REQ-027 S_ERR SHALL be terminal until reset: o_MemReq=0, o_Busy=0, all inputs ignored, o_MisalignErr held at 1.
REQ-028 i_PcLoad or i_PcTarget without i_Advance SHALL have no effect in any state.
REQ-029 i_MemAck outside S_FETCH SHALL be ignored, with IR unchanged.
REQ-030 o_MemAddr SHALL always equal PC; o_MemReq SHALL be a pure function of state, combinational from registered state.

Reset
REQ-031 On an edge with i_Rst=1: state<=S_FETCH; PC<=P_RESET_PC; IR<=P_NOP; o_Pc<=P_RESET_PC; o_InstValid<=0; o_MisalignErr<=0.
REQ-032 Reset SHALL take priority over i_MemAck and i_Advance on the same edge.
REQ-033 Reset during a fetch SHALL abort it; the next request SHALL target P_RESET_PC.
REQ-034 In the first cycle after reset the block SHALL drive o_MemReq=1, o_MemAddr=P_RESET_PC, o_Busy=1 and o_OpCode=7'h13.

Verification
REQ-035 The bench SHALL cover sequential fetch: reset, then memory acks after 2 wait cycles with 32'h0050_0093, then advance with i_PcLoad=0 -> o_Inst=32'h0050_0093, o_OpCode=7'h13, o_Pc=0, then o_MemAddr=4 and o_MemReq=1.
REQ-036 The bench SHALL cover a taken branch: in S_VALID, i_Advance=1, i_PcLoad=1, i_PcTarget=32'h0000_0100 -> next cycle o_MemAddr=32'h100 and o_InstValid=0.
REQ-037 The bench SHALL cover a misaligned target: i_PcTarget=32'h0000_0102 with advance -> o_MisalignErr=1 and o_MemReq=0 permanently; i_MemAck and i_Advance are then ignored; i_Rst clears the error.
REQ-038 The bench SHALL cover wrap-around: P_RESET_PC=32'hFFFF_FFFC, fetch, advance with i_PcLoad=0 -> o_MemAddr=0.
REQ-039 The bench SHALL cover reset mid-fetch: i_Rst=1 and i_MemAck=1 on the same edge -> IR=P_NOP, o_InstValid=0, o_MemAddr=P_RESET_PC.
REQ-040 The bench SHALL cover spurious inputs: i_MemAck pulses in S_VALID and i_Advance pulses in S_FETCH -> o_Inst, o_Pc and PC unchanged.
